// File: rtl/pic_host_bus_master.sv
// Host-side bus cycle generator for the 8259 PIC bus interface.
// Turns single-beat write/read/INTA requests into timed cs_n/rd_n/wr_n/inta_n
// sequences with programmable setup, strobe, gap and hold lengths, and returns
// read or vector data through a one-cycle response pulse.
module pic_host_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned INTA_GAP   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic       req_a0,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       inta_n,
  output logic       a0,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE1 = 3'd2,
    S_GAP     = 3'd3,
    S_STROBE2 = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_INTA = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  localparam logic [3:0] SETUP_RL  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_RL = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_RL   = 4'(HOLD_CYC - 1);
  localparam logic [3:0] GAP_RL    = 4'(INTA_GAP - 1);

  // Counter value loaded on entry to a state: the state lasts reload+1 cycles.
  function automatic logic [3:0] reload(input state_t s);
    case (s)
      S_SETUP:   reload = SETUP_RL;
      S_STROBE1: reload = STROBE_RL;
      S_GAP:     reload = GAP_RL;
      S_STROBE2: reload = STROBE_RL;
      S_HOLD:    reload = HOLD_RL;
      default:   reload = 4'd0;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic       addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       inta_n_q, inta_n_d;
  logic       a0_q, a0_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;
  logic       busy_d;

  assign req_ready = (state_q == S_IDLE);

  // Next-state sequencing, request latching and response data capture.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_a0;
          wdata_d = req_wdata;
          if (req_op == OP_RSV) begin
            // Reserved op completes immediately with no bus activity.
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'h00;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) state_d = S_STROBE1;
      end
      S_STROBE1: begin
        if (cnt_q == 4'd0) begin
          state_d = (op_q == OP_INTA) ? S_GAP : S_HOLD;
          // First INTA pulse data is discarded; only a read captures here.
          if (op_q == OP_RD) rsp_data_d = data_in;
        end
      end
      S_GAP: begin
        if (cnt_q == 4'd0) state_d = S_STROBE2;
      end
      S_STROBE2: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_HOLD;
          rsp_data_d = data_in;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          if (op_q == OP_WR) rsp_data_d = 8'h00;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q) ? reload(state_d)
          : (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
  end

  // Bus pins are decoded from the upcoming state so each phase appears on
  // registered outputs in the very cycle the state is occupied.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    cs_n_d     = ~(busy_d && (op_d != OP_INTA));
    a0_d       = (busy_d && (op_d != OP_INTA)) ? addr_d : 1'b0;
    data_oe_d  = busy_d && (op_d == OP_WR);
    data_out_d = data_oe_d ? wdata_d : 8'h00;
    wr_n_d     = ~((state_d == S_STROBE1) && (op_d == OP_WR));
    rd_n_d     = ~((state_d == S_STROBE1) && (op_d == OP_RD));
    inta_n_d   = ~(((state_d == S_STROBE1) || (state_d == S_STROBE2)) &&
                   (op_d == OP_INTA));
  end

  // State, counter, latched request and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      op_q        <= OP_WR;
      addr_q      <= 1'b0;
      wdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      inta_n_q    <= 1'b1;
      a0_q        <= 1'b0;
      data_out_q  <= 8'h00;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      inta_n_q    <= inta_n_d;
      a0_q        <= a0_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign cs_n      = cs_n_q;
  assign rd_n      = rd_n_q;
  assign wr_n      = wr_n_q;
  assign inta_n    = inta_n_q;
  assign a0        = a0_q;
  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Bench for pic_host_bus_master: directed transactions with literal
// expectations, then randomized traffic checked every cycle against a
// schedule-based model of the bus timing rules.
module tb_pic_host_bus_master;

  localparam int S = 1;
  localparam int T = 2;
  localparam int H = 1;
  localparam int G = 2;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic       req_a0;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       cs_n, rd_n, wr_n, inta_n, a0;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;

  int vectors    = 0;
  int miscompares = 0;

  pic_host_bus_master #(
    .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .INTA_GAP(G)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a0(req_a0), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .inta_n(inta_n), .a0(a0),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
  );

  always #5 clk = ~clk;

  // Expected pin values for one clock period.
  typedef struct {
    logic       cs_n, rd_n, wr_n, inta_n, a0, oe;
    logic [7:0] dout;
    logic       rsp, busy, cap, zero;
  } exp_t;

  exp_t       sched[$];
  exp_t       cur;
  logic [7:0] m_rsp;

  function automatic exp_t idle_e();
    exp_t e;
    e.cs_n = 1'b1; e.rd_n = 1'b1; e.wr_n = 1'b1; e.inta_n = 1'b1;
    e.a0 = 1'b0; e.oe = 1'b0; e.dout = 8'h00;
    e.rsp = 1'b0; e.busy = 1'b0; e.cap = 1'b0; e.zero = 1'b0;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Lay out the whole transaction cycle by cycle from the timing formulas.
  task automatic build(input logic [1:0] op, input logic a, input logic [7:0] wd);
    exp_t e;
    int   len;
    bit   in1, in2;
    if (op == 2'b11) begin
      e = idle_e(); e.rsp = 1'b1; e.zero = 1'b1;
      sched.push_back(e);
      return;
    end
    len = (op == 2'b10) ? S + 2*T + G + H : S + T + H;
    for (int n = 0; n < len; n++) begin
      e = idle_e();
      e.busy = 1'b1;
      in1 = (n >= S) && (n < S + T);
      in2 = (op == 2'b10) && (n >= S + T + G) && (n < S + 2*T + G);
      case (op)
        2'b00: begin
          e.cs_n = 1'b0; e.a0 = a; e.oe = 1'b1; e.dout = wd; e.wr_n = !in1;
        end
        2'b01: begin
          e.cs_n = 1'b0; e.a0 = a; e.rd_n = !in1; e.cap = (n == S + T - 1);
        end
        default: begin
          e.inta_n = !(in1 || in2); e.cap = (n == S + 2*T + G - 1);
        end
      endcase
      sched.push_back(e);
    end
    e = idle_e(); e.rsp = 1'b1; e.zero = (op == 2'b00);
    sched.push_back(e);
  endtask

  // Reference model: advances one scheduled period per edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched.delete();
      cur   = idle_e();
      m_rsp = 8'h00;
    end else begin
      if (cur.cap) m_rsp = data_in;
      if (sched.size() == 0 && req_valid) build(req_op, req_a0, req_wdata);
      if (sched.size() != 0) cur = sched.pop_front();
      else cur = idle_e();
      if (cur.zero) m_rsp = 8'h00;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) chk("rst_rsp_data", rsp_data, 0);
    chk("cs_n", cs_n, cur.cs_n);
    chk("rd_n", rd_n, cur.rd_n);
    chk("wr_n", wr_n, cur.wr_n);
    chk("inta_n", inta_n, cur.inta_n);
    chk("data_oe", data_oe, cur.oe);
    chk("rsp_valid", rsp_valid, cur.rsp);
    chk("req_ready", req_ready, !cur.busy);
    if (cur.busy) chk("a0", a0, cur.a0);
    if (cur.oe) chk("data_out", data_out, cur.dout);
    if (cur.rsp) chk("rsp_data", rsp_data, m_rsp);
  end

  // One directed transaction; records per-cycle activity masks from accept.
  task automatic run_txn(input logic [1:0] op, input logic a, input logic [7:0] wd,
                         input logic [7:0] d1, input logic [7:0] d2,
                         output logic [11:0] csm, output logic [11:0] strm,
                         output logic [11:0] oem, output int rcyc,
                         output logic [7:0] rdat);
    int k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    if (k == 20) chk("ready_timeout", 0, 1);
    req_valid = 1'b1; req_op = op; req_a0 = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    csm = '0; strm = '0; oem = '0; rcyc = -1; rdat = 8'h00;
    for (int n = 0; n < 12; n++) begin
      data_in = (n >= 1 && n < 3) ? d1 : (n >= 5 && n < 7) ? d2 : 8'h00;
      @(negedge clk);
      csm[n]  = !cs_n;
      strm[n] = !(rd_n && wr_n && inta_n);
      oem[n]  = data_oe;
      if (rsp_valid && rcyc < 0) begin
        rcyc = n; rdat = rsp_data;
      end
      @(posedge clk); #1;
    end
  endtask

  logic [11:0] csm, strm, oem;
  int          rcyc, r1, r2;
  logic [7:0]  rdat;

  initial begin
    clk = 1'b0; rst_n = 1'b1; req_valid = 1'b0; req_op = 2'b00;
    req_a0 = 1'b0; req_wdata = 8'h00; data_in = 8'h00;
    cur = idle_e(); m_rsp = 8'h00;
    #1 rst_n = 1'b0;
    // Reset held with a pending request: no bus activity allowed.
    req_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_data_oe", data_oe, 0);
    #2 rst_n = 1'b1;

    run_txn(2'b00, 1'b0, 8'h13, 8'h00, 8'h00, csm, strm, oem, rcyc, rdat);
    chk("wr_cs_mask", csm, 12'h00F);
    chk("wr_strobe_mask", strm, 12'h006);
    chk("wr_oe_mask", oem, 12'h00F);
    chk("wr_rsp_cycle", rcyc, 4);
    chk("wr_rsp_data", rdat, 8'h00);

    run_txn(2'b01, 1'b1, 8'h00, 8'hA5, 8'h00, csm, strm, oem, rcyc, rdat);
    chk("rd_cs_mask", csm, 12'h00F);
    chk("rd_strobe_mask", strm, 12'h006);
    chk("rd_oe_mask", oem, 12'h000);
    chk("rd_rsp_cycle", rcyc, 4);
    chk("rd_rsp_data", rdat, 8'hA5);

    run_txn(2'b10, 1'b0, 8'h00, 8'hFF, 8'h48, csm, strm, oem, rcyc, rdat);
    chk("inta_cs_mask", csm, 12'h000);
    chk("inta_strobe_mask", strm, 12'h066);
    chk("inta_rsp_cycle", rcyc, 8);
    chk("inta_rsp_data", rdat, 8'h48);

    // Back-to-back writes with req_valid held high.
    req_valid = 1'b1; req_op = 2'b00; req_a0 = 1'b1; req_wdata = 8'h13;
    @(posedge clk); #1;
    req_wdata = 8'h48;
    csm = '0; r1 = -1; r2 = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      csm[n] = !cs_n;
      if (n == 0) chk("b2b_dout0", data_out, 8'h13);
      if (n == 5) chk("b2b_dout1", data_out, 8'h48);
      if (rsp_valid) begin
        if (r1 < 0) r1 = n; else if (r2 < 0) r2 = n;
      end
      @(posedge clk); #1;
      if (n == 4) req_valid = 1'b0;
    end
    chk("b2b_cs_mask", csm, 12'h1EF);
    chk("b2b_rsp1", r1, 4);
    chk("b2b_rsp2", r2, 9);

    // Asynchronous reset during the first wr_n-low cycle.
    req_valid = 1'b1; req_op = 2'b00; req_a0 = 1'b0; req_wdata = 8'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_wr_low", wr_n, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_n", wr_n, 1);
    chk("mid_rst_cs_n", cs_n, 1);
    chk("mid_rst_oe", data_oe, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(2'b01, 1'b0, 8'h00, 8'hA5, 8'h00, csm, strm, oem, rcyc, rdat);
    chk("post_rst_rd_cycle", rcyc, 4);
    chk("post_rst_rd_data", rdat, 8'hA5);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int c = 0; c < 1500; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_op    = 2'($urandom_range(0, 3));
      req_a0    = 1'($urandom_range(0, 1));
      req_wdata = 8'($urandom);
      data_in   = 8'($urandom);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
